// File: rtl/twiddle_feeder.sv
// Buffers one 16-sample complex float32 frame, then streams each sample
// paired with its W16^(p*q) twiddle to the FFT complex multiplier.
module twiddle_feeder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_real,
   input  logic [31:0] in_im,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] a_real,
   output logic [31:0] a_im,
   output logic [31:0] b_real,
   output logic [31:0] b_im,
   output logic [3:0]  out_index,
   output logic        out_last
);

   typedef enum logic {LOAD, ISSUE} state_t;

   state_t      state, state_nxt;
   logic [63:0] frame_buf [16];
   logic [3:0]  wr_ptr, rd_ptr;
   logic        accept, fire, load_done;

   // Twiddle for index i = 4p + q is W16^(p*q); only seven exponents occur.
   function automatic logic [63:0] twiddle(input logic [3:0] idx);
      logic [3:0] e;
      e = {2'b00, idx[3:2]} * {2'b00, idx[1:0]};
      case (e)
         4'd0:    twiddle = {32'h3F800000, 32'h00000000};
         4'd1:    twiddle = {32'h3F6C835E, 32'hBEC3EF15};
         4'd2:    twiddle = {32'h3F3504F3, 32'hBF3504F3};
         4'd3:    twiddle = {32'h3EC3EF15, 32'hBF6C835E};
         4'd4:    twiddle = {32'h00000000, 32'hBF800000};
         4'd6:    twiddle = {32'hBF3504F3, 32'hBF3504F3};
         4'd9:    twiddle = {32'hBF6C835E, 32'h3EC3EF15};
         default: twiddle = 64'h0;
      endcase
   endfunction

   assign accept    = in_valid & in_ready;
   assign fire      = out_valid & out_ready;
   assign load_done = accept & (wr_ptr == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (load_done) state_nxt = ISSUE;
         ISSUE:   if (fire && rd_ptr == 4'd15) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_comb begin
      in_ready = (state == LOAD);
   end

   // NOTE: sample storage has no reset; it is always written before it is read.
   always_ff @(posedge clk) begin
      if (accept) frame_buf[wr_ptr] <= {in_real, in_im};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         a_real    <= '0;
         a_im      <= '0;
         b_real    <= '0;
         b_im      <= '0;
      end else begin
         if (load_done) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            out_valid        <= 1'b1;
            {a_real, a_im}   <= frame_buf[0];
            {b_real, b_im}   <= twiddle(4'd0);
         end else if (accept) begin
            wr_ptr <= wr_ptr + 4'd1;
         end

         if (fire) begin
            if (rd_ptr != 4'd15) begin
               rd_ptr         <= rd_ptr + 4'd1;
               {a_real, a_im} <= frame_buf[rd_ptr + 4'd1];
               {b_real, b_im} <= twiddle(rd_ptr + 4'd1);
            end else begin
               rd_ptr    <= '0;
               out_valid <= 1'b0;
            end
         end
      end
   end

   assign out_index = rd_ptr;
   assign out_last  = out_valid & (rd_ptr == 4'd15);

endmodule

// File: tb/tb_twiddle_feeder.sv
// Directed and lightly randomised bench for twiddle_feeder; every expected
// pair comes from the bench's own frame arrays and hand-derived twiddle table.
module tb_twiddle_feeder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_real, in_im;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] a_real, a_im, b_real, b_im;
   logic [3:0]  out_index;
   logic        out_last;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] fr_re [16];
   logic [31:0] fr_im [16];
   logic [63:0] seen_b [16];

   localparam logic [31:0] SENTINEL = 32'h7FC00000;

   twiddle_feeder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_real    (a_real),
      .a_im      (a_im),
      .b_real    (b_real),
      .b_im      (b_im),
      .out_index (out_index),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   // float32 encodings of the integers 0..15
   function automatic logic [31:0] flt(input int i);
      case (i)
         0: flt = 32'h00000000;  1: flt = 32'h3F800000;  2: flt = 32'h40000000;
         3: flt = 32'h40400000;  4: flt = 32'h40800000;  5: flt = 32'h40A00000;
         6: flt = 32'h40C00000;  7: flt = 32'h40E00000;  8: flt = 32'h41000000;
         9: flt = 32'h41100000; 10: flt = 32'h41200000; 11: flt = 32'h41300000;
        12: flt = 32'h41400000; 13: flt = 32'h41500000; 14: flt = 32'h41600000;
         default: flt = 32'h41700000;
      endcase
   endfunction

   // Twiddle per frame index, exponents worked out by hand from p*q.
   function automatic logic [63:0] tw_exp(input int i);
      case (i)
         5:       tw_exp = {32'h3F6C835E, 32'hBEC3EF15};
         6, 9:    tw_exp = {32'h3F3504F3, 32'hBF3504F3};
         7, 13:   tw_exp = {32'h3EC3EF15, 32'hBF6C835E};
         10:      tw_exp = {32'h00000000, 32'hBF800000};
         11, 14:  tw_exp = {32'hBF3504F3, 32'hBF3504F3};
         15:      tw_exp = {32'hBF6C835E, 32'h3EC3EF15};
         default: tw_exp = {32'h3F800000, 32'h00000000};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #3;
      rst_n = 1'b1;
      step();
   endtask

   // Feed fr_re/fr_im; returns one cycle after the 16th accept.
   task automatic load_frame(input string tag, input bit rnd);
      int k = 0;
      int guard = 0;
      bit v;
      while (k < 16 && guard < 300) begin
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = v;
         in_real  = fr_re[k];
         in_im    = fr_im[k];
         tests++;
         if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL %s load k=%0d: in_ready/out_valid=%b required 10", tag, k, {in_ready, out_valid});
         end
         step();
         guard++;
         if (v) k++;
      end
      in_valid = 1'b0;
      tests++;
      if (k < 16) begin
         fails++;
         $display("FAIL %s load timeout: accepted %0d required 16", tag, k);
      end
   endtask

   // Drain one frame, checking every cycle; optional stall at one index or random ready.
   task automatic drain(input string tag, input int stall_idx, input bit rnd,
                        output int cyc, output int lasts);
      int i_exp = 0;
      int stalled = 0;
      bit rdy;
      logic [134:0] obs, exp;
      cyc = 0;
      lasts = 0;
      while (i_exp < 16 && cyc < 300) begin
         if (rnd) rdy = 1'($urandom_range(0, 1));
         else     rdy = !(i_exp == stall_idx && stalled < 3);
         if (!rdy && i_exp == stall_idx) stalled++;
         out_ready = rdy;
         obs = {in_ready, out_valid, out_index, a_real, a_im, b_real, b_im, out_last};
         exp = {1'b0, 1'b1, 4'(i_exp), fr_re[i_exp], fr_im[i_exp], tw_exp(i_exp), i_exp == 15};
         tests++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL %s pair %0d: got %h required %h", tag, i_exp, obs, exp);
         end
         if (rdy) begin
            seen_b[i_exp] = {b_real, b_im};
            if (out_last) lasts++;
         end
         step();
         cyc++;
         if (rdy) i_exp++;
      end
      out_ready = 1'b1;
      tests++;
      if (i_exp < 16) begin
         fails++;
         $display("FAIL %s drain timeout: drained %0d required 16", tag, i_exp);
      end
      tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         fails++;
         $display("FAIL %s after drain: out_valid/in_ready=%b required 01", tag, {out_valid, in_ready});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'($urandom);
         in_real = $urandom;
         in_im = $urandom;
         out_ready = 1'($urandom);
         step();
         tests++;
         if ({in_ready, out_valid, out_last, out_index, a_real, a_im, b_real, b_im} !== {3'b100, 4'd0, 128'd0}) begin
            fails++;
            $display("FAIL reset_hold: got %b %b %b %h %h%h%h%h required 1 0 0 0 and zero buses",
                     in_ready, out_valid, out_last, out_index, a_real, a_im, b_real, b_im);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b1;
      step();
      for (int k = 0; k < 15; k++) begin
         in_valid = 1'b1;
         in_real = $urandom;
         in_im = $urandom;
         step();
      end
      in_valid = 1'b0;
      step();
      tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         fails++;
         $display("FAIL reset_15_accepts: out_valid/in_ready=%b required 01", {out_valid, in_ready});
      end
   endtask

   task automatic test_basic();
      int cyc, lasts;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         fr_re[i] = flt(i);
         fr_im[i] = 32'h0;
      end
      load_frame("basic", 1'b0);
      tests++;
      if ({out_valid, out_index, a_real} !== {1'b1, 4'd0, 32'h00000000}) begin
         fails++;
         $display("FAIL basic_latency: got %b %h %h required 1 0 00000000", out_valid, out_index, a_real);
      end
      drain("basic", -1, 1'b0, cyc, lasts);
      tests++;
      if (cyc !== 16) begin fails++; $display("FAIL basic_drain_cycles: got %0d required 16", cyc); end
      tests++;
      if (seen_b[5] !== 64'h3F6C835E_BEC3EF15) begin fails++; $display("FAIL basic_b5: got %h required 3F6C835EBEC3EF15", seen_b[5]); end
      tests++;
      if (seen_b[10] !== 64'h00000000_BF800000) begin fails++; $display("FAIL basic_b10: got %h required 00000000BF800000", seen_b[10]); end
      tests++;
      if (seen_b[15] !== 64'hBF6C835E_3EC3EF15) begin fails++; $display("FAIL basic_b15: got %h required BF6C835E3EC3EF15", seen_b[15]); end
      foreach (seen_b[i]) begin
         if (i <= 4 || i == 8 || i == 12) begin
            tests++;
            if (seen_b[i] !== 64'h3F800000_00000000) begin
               fails++;
               $display("FAIL basic_b_unity i=%0d: got %h required 3F80000000000000", i, seen_b[i]);
            end
         end
      end
      tests++;
      if (lasts !== 1) begin fails++; $display("FAIL basic_last_count: got %0d required 1", lasts); end
   endtask

   task automatic test_backpressure();
      int cyc, lasts;
      for (int i = 0; i < 16; i++) begin
         fr_re[i] = 32'h1000_0000 + 32'(i);
         fr_im[i] = 32'hA000_0000 ^ 32'(i * 3);
      end
      load_frame("bp", 1'b0);
      drain("bp", 7, 1'b0, cyc, lasts);
      tests++;
      if (cyc !== 19) begin fails++; $display("FAIL bp_drain_cycles: got %0d required 19", cyc); end
   endtask

   task automatic test_issue_input();
      int cyc, lasts;
      for (int i = 0; i < 16; i++) begin
         fr_re[i] = 32'h2000_0000 + 32'(i);
         fr_im[i] = 32'h0000_0100 + 32'(i);
      end
      load_frame("issue_in", 1'b0);
      in_valid = 1'b1;
      in_real = SENTINEL;
      in_im = SENTINEL;
      drain("issue_in", -1, 1'b0, cyc, lasts);
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         fr_re[i] = 32'h3000_0000 + 32'(i);
         fr_im[i] = 32'h4000_0000 + 32'(i);
      end
      load_frame("issue_next", 1'b0);
      tests++;
      if (a_real === SENTINEL || a_real !== 32'h3000_0000) begin
         fails++;
         $display("FAIL issue_next_idx0: got %h required 30000000", a_real);
      end
      drain("issue_next", -1, 1'b0, cyc, lasts);
   endtask

   task automatic test_reset_mid_issue();
      int cyc, lasts;
      for (int i = 0; i < 16; i++) begin
         fr_re[i] = 32'h5000_0000 + 32'(i);
         fr_im[i] = 32'h6000_0000 + 32'(i);
      end
      load_frame("rst_mid", 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) step();
      out_ready = 1'b0;
      tests++;
      if ({out_valid, out_index} !== {1'b1, 4'd9}) begin
         fails++;
         $display("FAIL rst_mid_pre: got %b %h required 1 9", out_valid, out_index);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({in_ready, out_valid, out_last, out_index, a_real, a_im, b_real, b_im} !== {3'b100, 4'd0, 128'd0}) begin
         fails++;
         $display("FAIL rst_mid_async: got %b %b %b %h %h required 1 0 0 0 and zero buses",
                  in_ready, out_valid, out_last, out_index, a_real);
      end
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      for (int i = 0; i < 16; i++) begin
         fr_re[i] = 32'h7000_0000 + 32'(i);
         fr_im[i] = 32'h0800_0000 + 32'(i);
      end
      load_frame("rst_mid_fresh", 1'b0);
      drain("rst_mid_fresh", -1, 1'b0, cyc, lasts);
   endtask

   task automatic test_random();
      int cyc, lasts;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 16; i++) begin
            fr_re[i] = $urandom;
            fr_im[i] = $urandom;
         end
         fr_re[3] = SENTINEL;
         fr_im[4] = 32'h0000_0001;
         load_frame("random", 1'b1);
         drain("random", -1, 1'b1, cyc, lasts);
         tests++;
         if (lasts !== 1) begin fails++; $display("FAIL random_last_count f=%0d: got %0d required 1", f, lasts); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_real = '0;
      in_im = '0;
      out_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_issue_input();
      test_reset_mid_issue();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
